alu_result_serializer: RTL
==========================

Name: alu_result_serializer

Overview:
- Downstream stage of the system arithmetic unit.
- Captures each valid ALU result (Arith_OUT qualified by Arith_Flag), buffers it in a small FIFO and splits it into bytes.
- Feeds the bytes to the UART transmitter through its valid/busy handshake.
- Decouples single-cycle ALU result pulses from the slow serial link.

Parameters:
- DATA_WIDTH, 8: UART byte width.
- RESULT_WIDTH, 16: ALU result width. RESULT_WIDTH must equal 2*DATA_WIDTH; this is a design constraint.
- FIFO_DEPTH, 4: number of whole results buffered. Must be a power of 2, at least 2.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- ALU_OUT  in  RESULT_WIDTH  ALU result word.
- OUT_VALID  in  1  ALU result valid, one-cycle pulse per result.
- TX_BUSY  in  1  UART TX busy. High from the cycle after TX_D_VLD until the frame completes.
- TX_P_DATA  out  DATA_WIDTH  byte to UART TX.
- TX_D_VLD  out  1  byte valid, one-cycle pulse.
- FIFO_FULL  out  1  FIFO holds FIFO_DEPTH results.
- FIFO_EMPTY  out  1  FIFO holds no results.
- OVERFLOW  out  1  one-cycle pulse when an OUT_VALID result is dropped.

Behaviour:
- Reset (RST=1, any time, asynchronous):
  - pointers and count = 0, FSM -> IDLE.
  - TX_P_DATA=0, TX_D_VLD=0, OVERFLOW=0, FIFO_FULL=0, FIFO_EMPTY=1.
  - A byte or result in flight is discarded; no partial frame resumes after reset.
- FIFO:
  - Storage is a register array of RESULT_WIDTH words; count has log2(FIFO_DEPTH)+1 bits.
  - Pointers wrap modulo FIFO_DEPTH.
  - FIFO_FULL = (count==FIFO_DEPTH); FIFO_EMPTY = (count==0). Both are registered-count derived.
- Write:
  - OUT_VALID=1 and (count<FIFO_DEPTH, or a pop occurs in the same cycle): ALU_OUT is written at wr_ptr and wr_ptr increments.
  - OUT_VALID=1, count==FIFO_DEPTH and no pop: result dropped, OVERFLOW=1 next cycle for exactly one cycle.
- Pop:
  - Occurs in IDLE when count>0 and TX_BUSY=0.
  - Head word is loaded into the internal shift register hold_q, rd_ptr increments, FSM -> SEND_LO.
  - Simultaneous push and pop leaves count unchanged.
- FSM states: IDLE, SEND_LO, WAIT_LO_H, WAIT_LO_L, SEND_HI, WAIT_HI_H, WAIT_HI_L.
  - SEND_LO: TX_P_DATA=hold_q[DATA_WIDTH-1:0], TX_D_VLD=1 for one cycle -> WAIT_LO_H.
  - WAIT_LO_H: stay until TX_BUSY=1, then -> WAIT_LO_L.
  - WAIT_LO_L: stay until TX_BUSY=0, then -> SEND_HI.
  - SEND_HI: TX_P_DATA=hold_q[RESULT_WIDTH-1:DATA_WIDTH], TX_D_VLD=1 one cycle -> WAIT_HI_H.
  - WAIT_HI_H / WAIT_HI_L: same as the LO pair; WAIT_HI_L exits to IDLE.
- Byte order and data hold:
  - Low byte is always sent first.
  - TX_P_DATA holds its last value between pulses; it is not zeroed.
- Latency:
  - OUT_VALID into an empty FIFO with TX idle: written at edge N, popped at N+1, TX_D_VLD high during cycle N+2.
- No timeout: the FSM waits indefinitely on TX_BUSY. TX_BUSY is treated as synchronous to CLK.
- Writes continue while the FSM is in any state.

Optional Feature:
- Macro ALU_SER_FRAME_TAG_EN.
- Defined:
  - Adds states SEND_TAG, WAIT_TAG_H, WAIT_TAG_L before SEND_LO.
  - Each result is preceded by tag byte 8'hA5 using the same handshake, giving 3 bytes per result.
  - Pop then goes IDLE -> SEND_TAG.
- Undefined: 2 bytes per result, no tag states exist, and first TX_D_VLD latency is as stated above.

Test Plan:
- Reset: assert RST mid-frame while in WAIT_LO_L -> outputs return to reset values immediately; after release with FIFO empty, no TX_D_VLD ever occurs.
- Single result: ALU_OUT=16'h12C4 with OUT_VALID pulse; bench TX_BUSY model 10 cycles -> TX_D_VLD with TX_P_DATA=8'hC4, then 8'h12 only after TX_BUSY falls; FIFO_EMPTY back to 1.
- Fill and overflow: hold TX_BUSY=1, then pulse 5 results 16'h0001..16'h0005 -> FIFO_FULL=1 after the 4th; 5th dropped with OVERFLOW pulse; release TX_BUSY -> bytes 01,00,02,00,03,00,04,00 in order.
- Push and pop in one cycle: count=4 and FSM in IDLE with TX_BUSY=0, pulse OUT_VALID=16'hBEEF -> accepted with no OVERFLOW; count stays 4; 16'hBEEF is eventually sent as EF,BE.
- Wrap-around: stream 10 results 16'h0100+i spaced so the FIFO never fills -> all 20 bytes correct; pointers wrap twice.
- With ALU_SER_FRAME_TAG_EN defined: one result 16'h55AA -> byte sequence A5, AA, 55.

Source files
------------

// File: rtl/alu_result_serializer.sv
// Purpose : buffers ALU results in a FIFO and sends each one to the UART TX as bytes, low byte first.
// Latency : a result written at edge N is popped at N+1, and its first TX_D_VLD pulse follows in the next cycle.
// Backpress: each byte waits for TX_BUSY to rise and then fall; a result that arrives while the FIFO is full is dropped and OVERFLOW pulses.
// Optional : define ALU_SER_FRAME_TAG_EN to send tag byte 8'hA5 before every result.
// Note     : RESULT_WIDTH must be 2*DATA_WIDTH. FIFO_DEPTH must be a power of two and at least 2.
module alu_result_serializer #(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [RESULT_WIDTH-1:0] ALU_OUT,
  input  logic                    OUT_VALID,
  input  logic                    TX_BUSY,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  output logic                    FIFO_FULL,
  output logic                    FIFO_EMPTY,
  output logic                    OVERFLOW
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
`ifdef ALU_SER_FRAME_TAG_EN
  localparam logic [DATA_WIDTH-1:0] TAG_BYTE = DATA_WIDTH'(8'hA5);
`endif

  typedef enum logic [3:0] {
    IDLE,
    SEND_LO,
    WAIT_LO_H,
    WAIT_LO_L,
    SEND_HI,
    WAIT_HI_H,
    WAIT_HI_L
`ifdef ALU_SER_FRAME_TAG_EN
    ,
    SEND_TAG,
    WAIT_TAG_H,
    WAIT_TAG_L
`endif
  } state_t;

  logic [RESULT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q;
  logic [PTR_W-1:0]        rd_ptr_q;
  logic [CNT_W-1:0]        count_q;
  logic [RESULT_WIDTH-1:0] hold_q;
  logic [DATA_WIDTH-1:0]   last_q;
  logic                    ovf_q;
  state_t                  state_q;
  state_t                  state_d;
  logic                    pop;
  logic                    push;
  logic                    drop;

  // A pop is only taken from IDLE, so a new result never starts while the link is busy.
  assign pop  = (state_q == IDLE) && (count_q != '0) && !TX_BUSY;
  // A full FIFO still accepts a write when a pop frees a slot in the same cycle.
  assign push = OUT_VALID && ((count_q != DEPTH_C) || pop);
  assign drop = OUT_VALID && (count_q == DEPTH_C) && !pop;

  assign FIFO_FULL  = (count_q == DEPTH_C);
  assign FIFO_EMPTY = (count_q == '0);
  assign OVERFLOW   = ovf_q;

  // Result storage. It has no reset because the pointers and count decide which words are valid.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_q] <= ALU_OUT;
  end

  // FIFO pointers and occupancy. The pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Holding register for the result being sent; loaded with the head word on each pop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) hold_q <= '0;
    else if (pop) hold_q <= mem[rd_ptr_q];
  end

  // FSM state, the last byte presented, and the one-cycle overflow flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      last_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= TX_P_DATA;
      ovf_q   <= drop;
    end
  end

  // Next state and byte outputs. TX_P_DATA keeps showing the last byte when no byte is being sent.
  always_comb begin
    state_d   = state_q;
    TX_P_DATA = last_q;
    TX_D_VLD  = 1'b0;
    case (state_q)
      IDLE: begin
`ifdef ALU_SER_FRAME_TAG_EN
        if (pop) state_d = SEND_TAG;
`else
        if (pop) state_d = SEND_LO;
`endif
      end
`ifdef ALU_SER_FRAME_TAG_EN
      SEND_TAG: begin
        TX_P_DATA = TAG_BYTE;
        TX_D_VLD  = 1'b1;
        state_d   = WAIT_TAG_H;
      end
      WAIT_TAG_H: if (TX_BUSY)  state_d = WAIT_TAG_L;
      WAIT_TAG_L: if (!TX_BUSY) state_d = SEND_LO;
`endif
      SEND_LO: begin
        TX_P_DATA = hold_q[DATA_WIDTH-1:0];
        TX_D_VLD  = 1'b1;
        state_d   = WAIT_LO_H;
      end
      WAIT_LO_H: if (TX_BUSY)  state_d = WAIT_LO_L;
      WAIT_LO_L: if (!TX_BUSY) state_d = SEND_HI;
      SEND_HI: begin
        TX_P_DATA = hold_q[RESULT_WIDTH-1:DATA_WIDTH];
        TX_D_VLD  = 1'b1;
        state_d   = WAIT_HI_H;
      end
      WAIT_HI_H: if (TX_BUSY)  state_d = WAIT_HI_L;
      WAIT_HI_L: if (!TX_BUSY) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

endmodule
